// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// A registered output stage drives the write port. Writes to register 0 are consumed but never issued.
module regfile_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     wr_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [1:0]               rf_wsrc
);

  logic [1:0]        ptr;
  logic [1:0]        win;
  logic [1:0]        ptr_nxt;
  logic              found;
  logic              out_free;
  logic              xfer;
  logic [2:0]        idx;
  logic [3:0]        valid_ext;
  logic [3:0]        ready_ext;
  logic [ADDR_W-1:0] addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];

  // Pad the requester set to four slots so a 2-bit index always fits.
  for (genvar g = 0; g < 4; g++) begin : g_req
    if (g < N_REQ) begin : g_real
      assign valid_ext[g] = req_valid[g];
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign data_arr[g]  = req_data[g*DATA_W +: DATA_W];
    end else begin : g_none
      assign valid_ext[g] = 1'b0;
      assign addr_arr[g]  = '0;
      assign data_arr[g]  = '0;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(N_REQ)) idx = idx - 3'(N_REQ);
      if (!found && valid_ext[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  // Reset gates ready combinationally so no handshake completes while held.
  assign out_free  = !rf_we || !wr_stall;
  assign xfer      = reset && found && out_free;
  assign ready_ext = xfer ? (4'b0001 << win) : 4'b0000;
  assign req_ready = ready_ext[N_REQ-1:0];
  assign ptr_nxt   = (win == 2'(N_REQ-1)) ? 2'd0 : win + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_wsrc  <= '0;
      ptr      <= '0;
    end else if (out_free) begin
      if (xfer) begin
        ptr <= ptr_nxt;
        if (addr_arr[win] != '0) begin
          rf_we    <= 1'b1;
          rf_waddr <= addr_arr[win];
          rf_wdata <= data_arr[win];
          rf_wsrc  <= win;
        end else begin
          rf_we <= 1'b0;
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Each accepted write is queued as an expected output and checked one cycle later.
module tb_regfile_write_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wr_stall;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [1:0]   rf_wsrc;

  logic [4:0]  a [4];
  logic [31:0] d [4];

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
  } wr_t;

  wr_t  sb [$];
  wr_t  last;
  logic last_we;
  int   n_cmp;
  int   n_err;

  regfile_write_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wsrc(rf_wsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_addr[i*5 +: 5]   = a[i];
      req_data[i*32 +: 32] = d[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge with inputs already driven.
  task automatic cyc(input logic [3:0] exp_ready, input string tag);
    int   w;
    logic hold;
    logic pushed;
    wr_t  e;
    #1;
    check({tag, " ready"}, 64'(req_ready), 64'(exp_ready));
    w = -1;
    for (int i = 0; i < 4; i++) if (exp_ready[i]) w = i;
    pushed = 1'b0;
    if (w >= 0 && a[w] != 5'd0) begin
      sb.push_back('{addr: a[w], data: d[w], src: 2'(w)});
      pushed = 1'b1;
    end
    hold = last_we && wr_stall;
    @(posedge clk);
    #1;
    if (pushed) begin
      e = sb.pop_front();
      check({tag, " we"},    64'(rf_we),    64'(1));
      check({tag, " waddr"}, 64'(rf_waddr), 64'(e.addr));
      check({tag, " wdata"}, 64'(rf_wdata), 64'(e.data));
      check({tag, " wsrc"},  64'(rf_wsrc),  64'(e.src));
      last    = e;
      last_we = 1'b1;
    end else if (hold) begin
      check({tag, " hold we"},    64'(rf_we),    64'(1));
      check({tag, " hold waddr"}, 64'(rf_waddr), 64'(last.addr));
      check({tag, " hold wdata"}, 64'(rf_wdata), 64'(last.data));
    end else begin
      check({tag, " we"}, 64'(rf_we), 64'(0));
      last_we = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0; last_we = 1'b0; last = '0;
    reset = 1'b0; wr_stall = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'(i + 8);
      d[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset holds everything low even with all requesters valid.
    #12;
    check("rst ready", 64'(req_ready), 64'(0));
    check("rst we",    64'(rf_we),     64'(0));
    check("rst waddr", 64'(rf_waddr),  64'(0));
    check("rst wdata", 64'(rf_wdata),  64'(0));
    check("rst wsrc",  64'(rf_wsrc),   64'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // Round-robin with all four valid.
    cyc(4'b0001, "rr0");
    cyc(4'b0010, "rr1");
    cyc(4'b0100, "rr2");
    cyc(4'b1000, "rr3");
    cyc(4'b0001, "rr4");
    req_valid = 4'b0000;
    cyc(4'b0000, "idle");

    // Single write from requester 2 (ptr now 1).
    req_valid = 4'b0100; a[2] = 5'd5; d[2] = 32'hDEADBEEF;
    cyc(4'b0100, "single");
    req_valid = 4'b0000;
    cyc(4'b0000, "single_done");

    // Stall: requester 3 writes addr 7, then a 3-cycle stall with requester 1 waiting.
    req_valid = 4'b1000; a[3] = 5'd7; d[3] = 32'h0000_0777;
    cyc(4'b1000, "pre_stall");
    req_valid = 4'b0010; wr_stall = 1'b1;
    cyc(4'b0000, "stall0");
    cyc(4'b0000, "stall1");
    cyc(4'b0000, "stall2");
    wr_stall = 1'b0;
    cyc(4'b0010, "stall_rel");
    req_valid = 4'b0000;
    cyc(4'b0000, "post_stall");

    // $zero write from requester 0 (ptr 2), then ptr must be 1 so requester 3 beats 0.
    req_valid = 4'b0001; a[0] = 5'd0; d[0] = 32'h0000_1234;
    cyc(4'b0001, "zero");
    req_valid = 4'b1001; a[3] = 5'd4; d[3] = 32'h0000_0444;
    cyc(4'b1000, "after_zero");

    // Stall is ignored while the output is empty.
    req_valid = 4'b0000;
    cyc(4'b0000, "empty");
    req_valid = 4'b0100; wr_stall = 1'b1; a[2] = 5'd3; d[2] = 32'h3333_3333;
    cyc(4'b0100, "stall_empty");
    req_valid = 4'b0000;
    cyc(4'b0000, "stall_hold");

    // Asynchronous reset between edges while a write is stalled.
    req_valid = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst we",    64'(rf_we),     64'(0));
    check("async_rst ready", 64'(req_ready), 64'(0));
    reset = 1'b1;
    last_we = 1'b0;
    req_valid = 4'b0000;
    cyc(4'b0000, "no_reissue");
    req_valid = 4'b1111;
    cyc(4'b0001, "ptr_zero");
    wr_stall = 1'b0;
    req_valid = 4'b0000;
    cyc(4'b0000, "drain");

    check("sb empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
